// File: rtl/vpipe_stall_ctrl.sv
// Pipeline sequencing controller: RAW hazard stall, multi-beat vector memory
// sequencing in MEM, and a saturating stall-cycle counter.
module vpipe_stall_ctrl #(
    parameter int unsigned V     = 20,
    parameter int unsigned L     = 8,
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 32,
    localparam int unsigned BEATS  = (V + LANES - 1) / LANES,
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [4:0]        ID_A1_i,
    input  logic [4:0]        ID_A2_i,
    input  logic              ID_Use1_i,
    input  logic              ID_Use2_i,
    input  logic              ID_SrcVec_i,
    input  logic [4:0]        EX_A3_i,
    input  logic              EX_WE_i,
    input  logic              EX_DstVec_i,
    input  logic [4:0]        MEM_A3_i,
    input  logic              MEM_WE_i,
    input  logic              MEM_DstVec_i,
    input  logic              MEM_VMem_i,
    input  logic              VMem_Ack_i,
    output logic              PC_En_o,
    output logic              IF_ID_En_o,
    output logic              ID_EX_En_o,
    output logic              ID_EX_Flush_o,
    output logic              EX_MEM_En_o,
    output logic              MEM_WB_En_o,
    output logic              VMem_Req_o,
    output logic [BEAT_W-1:0] VMem_Beat_o,
    output logic              Busy_o,
    output logic [CNT_W-1:0]  Stall_Cnt_o
);

    if (V < 1 || L < 1 || LANES < 1 || CNT_W < 1) begin : g_param_check
        $error("vpipe_stall_ctrl: V, L, LANES and CNT_W must all be non-zero");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              haz;
    logic              mem_stall;
    logic              last_beat;

    // Scalar r0 is hard-wired zero, so it can never carry a RAW dependence.
    function automatic logic src_match(
        input logic [4:0] a,
        input logic       src_vec,
        input logic [4:0] ex_a3,
        input logic       ex_we,
        input logic       ex_vec,
        input logic [4:0] mem_a3,
        input logic       mem_we,
        input logic       mem_vec
    );
        logic m;
        m = (ex_we  && ex_a3  == a && ex_vec  == src_vec)
         || (mem_we && mem_a3 == a && mem_vec == src_vec);
        return m && !(!src_vec && a == 5'd0);
    endfunction

    always_comb begin
        haz = (ID_Use1_i && src_match(ID_A1_i, ID_SrcVec_i, EX_A3_i, EX_WE_i, EX_DstVec_i,
                                      MEM_A3_i, MEM_WE_i, MEM_DstVec_i))
           || (ID_Use2_i && src_match(ID_A2_i, ID_SrcVec_i, EX_A3_i, EX_WE_i, EX_DstVec_i,
                                      MEM_A3_i, MEM_WE_i, MEM_DstVec_i));
    end

    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
    assign mem_stall = (state_q == S_IDLE && MEM_VMem_i) || (state_q == S_BUSY);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (!PC_En_o && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (MEM_VMem_i) begin
                    state_d = S_BUSY;
                    beat_d  = '0;
                end
            end
            S_BUSY: begin
                if (VMem_Ack_i) begin
                    if (last_beat) begin
                        state_d = S_DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_comb begin
        PC_En_o       = 1'b1;
        IF_ID_En_o    = 1'b1;
        ID_EX_En_o    = 1'b1;
        ID_EX_Flush_o = 1'b0;
        EX_MEM_En_o   = 1'b1;
        MEM_WB_En_o   = 1'b1;
        VMem_Req_o    = 1'b0;
        VMem_Beat_o   = '0;
        Busy_o        = 1'b0;
        if (!RST) begin
            Busy_o = (state_q != S_IDLE);
            if (state_q == S_BUSY) begin
                VMem_Req_o  = 1'b1;
                VMem_Beat_o = beat_q;
            end
            // The memory stall freezes the whole pipe and takes precedence over a decode bubble.
            if (mem_stall) begin
                PC_En_o     = 1'b0;
                IF_ID_En_o  = 1'b0;
                ID_EX_En_o  = 1'b0;
                EX_MEM_En_o = 1'b0;
                MEM_WB_En_o = 1'b0;
            end else if (haz) begin
                PC_En_o       = 1'b0;
                IF_ID_En_o    = 1'b0;
                ID_EX_Flush_o = 1'b1;
            end
        end
    end

    assign Stall_Cnt_o = cnt_q;

endmodule

// File: tb/tb_vpipe_stall_ctrl.sv
// Directed bench for vpipe_stall_ctrl: expected outputs are queued when each
// step is driven and compared against two instances (full and narrow counter).
module tb_vpipe_stall_ctrl;

    localparam int RUN  = 0;
    localparam int HAZ  = 1;
    localparam int MEM  = 2;
    localparam int RSTM = 3;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST;
    logic [4:0] ID_A1_i, ID_A2_i, EX_A3_i, MEM_A3_i;
    logic       ID_Use1_i, ID_Use2_i, ID_SrcVec_i;
    logic       EX_WE_i, EX_DstVec_i, MEM_WE_i, MEM_DstVec_i, MEM_VMem_i, VMem_Ack_i;

    logic        a_pc, a_ifid, a_idex, a_fl, a_exm, a_mwb, a_req, a_busy;
    logic [2:0]  a_beat;
    logic [31:0] a_cnt;
    logic        b_pc, b_ifid, b_idex, b_fl, b_exm, b_mwb, b_req, b_busy;
    logic [2:0]  b_beat;
    logic [2:0]  b_cnt;

    vpipe_stall_ctrl #(.V(20), .L(8), .LANES(4), .CNT_W(32)) u_dut (
        .CLK(CLK), .RST(RST),
        .ID_A1_i(ID_A1_i), .ID_A2_i(ID_A2_i), .ID_Use1_i(ID_Use1_i), .ID_Use2_i(ID_Use2_i),
        .ID_SrcVec_i(ID_SrcVec_i), .EX_A3_i(EX_A3_i), .EX_WE_i(EX_WE_i),
        .EX_DstVec_i(EX_DstVec_i), .MEM_A3_i(MEM_A3_i), .MEM_WE_i(MEM_WE_i),
        .MEM_DstVec_i(MEM_DstVec_i), .MEM_VMem_i(MEM_VMem_i), .VMem_Ack_i(VMem_Ack_i),
        .PC_En_o(a_pc), .IF_ID_En_o(a_ifid), .ID_EX_En_o(a_idex), .ID_EX_Flush_o(a_fl),
        .EX_MEM_En_o(a_exm), .MEM_WB_En_o(a_mwb), .VMem_Req_o(a_req),
        .VMem_Beat_o(a_beat), .Busy_o(a_busy), .Stall_Cnt_o(a_cnt)
    );

    vpipe_stall_ctrl #(.V(20), .L(8), .LANES(4), .CNT_W(3)) u_sat (
        .CLK(CLK), .RST(RST),
        .ID_A1_i(ID_A1_i), .ID_A2_i(ID_A2_i), .ID_Use1_i(ID_Use1_i), .ID_Use2_i(ID_Use2_i),
        .ID_SrcVec_i(ID_SrcVec_i), .EX_A3_i(EX_A3_i), .EX_WE_i(EX_WE_i),
        .EX_DstVec_i(EX_DstVec_i), .MEM_A3_i(MEM_A3_i), .MEM_WE_i(MEM_WE_i),
        .MEM_DstVec_i(MEM_DstVec_i), .MEM_VMem_i(MEM_VMem_i), .VMem_Ack_i(VMem_Ack_i),
        .PC_En_o(b_pc), .IF_ID_En_o(b_ifid), .ID_EX_En_o(b_idex), .ID_EX_Flush_o(b_fl),
        .EX_MEM_En_o(b_exm), .MEM_WB_En_o(b_mwb), .VMem_Req_o(b_req),
        .VMem_Beat_o(b_beat), .Busy_o(b_busy), .Stall_Cnt_o(b_cnt)
    );

    typedef struct {
        string       tag;
        logic [10:0] flags;
        logic [31:0] cnt;
        logic [2:0]  cnt_s;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cnt_model = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flag order: pc, if_id, id_ex, flush, ex_mem, mem_wb, req, busy, beat[2:0].
    task automatic step(input string tag, input int mode, input logic req,
                        input logic busy, input logic [2:0] beat);
        exp_t e, got;
        logic [5:0] en;
        case (mode)
            HAZ:     en = 6'b001111;
            MEM:     en = 6'b000000;
            default: en = 6'b111011;
        endcase
        e.tag   = tag;
        e.flags = {en, req, busy, beat};
        e.cnt   = cnt_model;
        e.cnt_s = (cnt_model > 7) ? 3'd7 : 3'(cnt_model);
        sb.push_back(e);
        @(negedge CLK);
        got = sb.pop_front();
        chk({got.tag, ".flags"},   {21'd0, a_pc, a_ifid, a_idex, a_fl, a_exm, a_mwb, a_req, a_busy, a_beat},
            {21'd0, got.flags});
        chk({got.tag, ".flags_s"}, {21'd0, b_pc, b_ifid, b_idex, b_fl, b_exm, b_mwb, b_req, b_busy, b_beat},
            {21'd0, got.flags});
        chk({got.tag, ".cnt"},   a_cnt, got.cnt);
        chk({got.tag, ".cnt_s"}, {29'd0, b_cnt}, {29'd0, got.cnt_s});
        if (mode == RSTM)   cnt_model = 0;
        else if (en[5] == 1'b0) cnt_model++;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ID_A1_i = '0; ID_A2_i = '0; ID_Use1_i = 0; ID_Use2_i = 0; ID_SrcVec_i = 0;
        EX_A3_i = '0; EX_WE_i = 0; EX_DstVec_i = 0;
        MEM_A3_i = '0; MEM_WE_i = 0; MEM_DstVec_i = 0; MEM_VMem_i = 0; VMem_Ack_i = 0;
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        @(posedge CLK);
        #1;
        // Reset forces run-mode outputs even with a vector op and hazard present.
        MEM_VMem_i = 1; ID_Use1_i = 1; ID_A1_i = 5'd3; EX_A3_i = 5'd3; EX_WE_i = 1;
        step("rst", RSTM, 0, 0, 3'd0);
        RST = 1'b0;
        clear_inputs();
        for (int i = 0; i < 10; i++) step("idle", RUN, 0, 0, 3'd0);

        ID_A1_i = 5'd3; ID_Use1_i = 1; EX_A3_i = 5'd3; EX_WE_i = 1;
        step("haz_ex_s3", HAZ, 0, 0, 3'd0);
        EX_DstVec_i = 1;
        step("nohaz_filemismatch", RUN, 0, 0, 3'd0);
        ID_A1_i = 5'd0; EX_A3_i = 5'd0; EX_DstVec_i = 0;
        step("nohaz_s0", RUN, 0, 0, 3'd0);
        ID_SrcVec_i = 1; EX_DstVec_i = 1;
        step("haz_v0", HAZ, 0, 0, 3'd0);
        EX_WE_i = 0; ID_SrcVec_i = 0; ID_Use1_i = 0;
        ID_Use2_i = 1; ID_A2_i = 5'd7; MEM_A3_i = 5'd7; MEM_WE_i = 1;
        step("haz_mem_src2", HAZ, 0, 0, 3'd0);
        MEM_DstVec_i = 1;
        step("nohaz_mem_vec", RUN, 0, 0, 3'd0);
        MEM_DstVec_i = 0; ID_Use2_i = 0;
        step("nohaz_nouse", RUN, 0, 0, 3'd0);
        clear_inputs();

        // Zero-wait vector op: ack in IDLE must be ignored, 7 cycles in MEM.
        MEM_VMem_i = 1; VMem_Ack_i = 1;
        step("v1_idle", MEM, 0, 0, 3'd0);
        for (int k = 0; k < 5; k++) step("v1_beat", MEM, 1, 1, 3'(k));
        step("v1_done", RUN, 0, 1, 3'd0);
        MEM_VMem_i = 0; VMem_Ack_i = 0;
        step("v1_after", RUN, 0, 0, 3'd0);

        // Ack withheld on beat 2 with a decode hazard pending throughout.
        ID_A1_i = 5'd3; ID_Use1_i = 1; EX_A3_i = 5'd3; EX_WE_i = 1;
        MEM_VMem_i = 1;
        step("v2_idle", MEM, 0, 0, 3'd0);
        VMem_Ack_i = 1;
        step("v2_b0", MEM, 1, 1, 3'd0);
        step("v2_b1", MEM, 1, 1, 3'd1);
        VMem_Ack_i = 0;
        for (int k = 0; k < 3; k++) step("v2_b2_wait", MEM, 1, 1, 3'd2);
        VMem_Ack_i = 1;
        step("v2_b2", MEM, 1, 1, 3'd2);
        step("v2_b3", MEM, 1, 1, 3'd3);
        step("v2_b4", MEM, 1, 1, 3'd4);
        step("v2_done_haz", HAZ, 0, 1, 3'd0);
        clear_inputs();
        step("v2_after", RUN, 0, 0, 3'd0);

        // Reset during beat 3 abandons the transfer and clears the counter.
        MEM_VMem_i = 1; VMem_Ack_i = 1;
        step("v3_idle", MEM, 0, 0, 3'd0);
        for (int k = 0; k < 3; k++) step("v3_beat", MEM, 1, 1, 3'(k));
        RST = 1'b1;
        step("v3_rst", RSTM, 0, 0, 3'd0);
        RST = 1'b0;
        clear_inputs();
        step("v3_post", RUN, 0, 0, 3'd0);
        step("v3_post2", RUN, 0, 0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
